// File: rtl/constant_burst_source_pkg.sv
// Shared definitions for the constant burst source: FSM encoding, default widths
// and zero constants.
package constant_burst_source_pkg;

   localparam int DEFAULT_WORD_WIDTH  = 8;
   localparam int DEFAULT_COUNT_WIDTH = 8;

   localparam logic [DEFAULT_WORD_WIDTH-1:0]  WORD_ZERO  = '0;
   localparam logic [DEFAULT_COUNT_WIDTH-1:0] COUNT_ZERO = '0;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/constant_burst_source_if.sv
// Ready/valid stream carrying the emitted word. A word moves on a rising edge where
// output_valid and output_ready are both high; once raised, valid and data hold until that happens.
interface constant_burst_source_if #(
   parameter int WORD_WIDTH = 8
) ();

   logic                  output_valid;
   logic                  output_ready;
   logic [WORD_WIDTH-1:0] output_data;

   modport master (
      output output_valid,
      output output_data,
      input  output_ready
   );

   modport slave (
      input  output_valid,
      input  output_data,
      output output_ready
   );

endinterface

// File: rtl/constant_burst_source_burst_down_counter.sv
// Loadable down-counter tracking the words still owed in the current burst.
module constant_burst_source_burst_down_counter
   import constant_burst_source_pkg::*;
#(
   parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic                   load,
   input  logic [COUNT_WIDTH-1:0] load_value,
   input  logic                   decrement,
   output logic                   is_one
);

   logic [COUNT_WIDTH-1:0] count;

   // Only ever decremented from a nonzero value, so it cannot wrap.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         count <= COUNT_WIDTH'(COUNT_ZERO);
      end else if (load) begin
         count <= load_value;
      end else if (decrement) begin
         count <= count - COUNT_WIDTH'(1);
      end
   end

   assign is_one = (count == COUNT_WIDTH'(1));

endmodule

// File: rtl/constant_burst_source.sv
// Captures a static word and a length on start, then emits that word length times
// on a ready/valid stream and pulses done when the burst completes.
module constant_burst_source
   import constant_burst_source_pkg::*;
#(
   parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
   parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic [WORD_WIDTH-1:0]  constant_in,
   input  logic [COUNT_WIDTH-1:0] burst_length,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output state_t                 fsm_state,
   constant_burst_source_if.master stream
);

   state_t                state;
   state_t                next_state;
   logic [WORD_WIDTH-1:0] data_reg;
   logic                  accept;
   logic                  zero_start;
   logic                  transfer;
   logic                  last_word;
   logic                  is_one;

   assign accept     = (state == ST_IDLE) && start && (burst_length != COUNT_WIDTH'(COUNT_ZERO));
   assign zero_start = (state == ST_IDLE) && start && (burst_length == COUNT_WIDTH'(COUNT_ZERO));
   assign transfer   = (state == ST_RUN) && stream.output_ready;
   assign last_word  = transfer && is_one;

   constant_burst_source_burst_down_counter #(
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_counter (
      .clock      (clock),
      .clear      (clear),
      .load       (accept),
      .load_value (burst_length),
      .decrement  (transfer),
      .is_one     (is_one)
   );

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (accept)    next_state = ST_RUN;
         ST_RUN:  if (last_word) next_state = ST_IDLE;
         default:                next_state = ST_IDLE;
      endcase
   end

   // Valid and data come only from registers, so ready never reaches them combinationally.
   always_comb begin
      busy                = 1'b0;
      stream.output_valid = 1'b0;
      stream.output_data  = data_reg;
      if (state == ST_RUN) begin
         busy                = 1'b1;
         stream.output_valid = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         data_reg <= WORD_WIDTH'(WORD_ZERO);
         done     <= 1'b0;
      end else begin
         if (accept) begin
            data_reg <= constant_in;
         end
         done <= last_word || zero_start;
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_constant_burst_source.sv
// Directed bench for constant_burst_source: reset, bursts under varied ready
// patterns, ignored restarts, zero length, mid-burst clear and maximum length.
module tb_constant_burst_source;
   import constant_burst_source_pkg::*;

   logic       clock = 1'b0;
   logic       clear;
   logic [7:0] constant_in;
   logic [7:0] burst_length;
   logic       start;
   logic       busy;
   logic       done;
   state_t     fsm_state;

   int errors = 0;
   int checks = 0;

   constant_burst_source_if #(.WORD_WIDTH(8)) stream ();

   constant_burst_source #(
      .WORD_WIDTH  (8),
      .COUNT_WIDTH (8)
   ) dut (
      .clock        (clock),
      .clear        (clear),
      .constant_in  (constant_in),
      .burst_length (burst_length),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .fsm_state    (fsm_state),
      .stream       (stream.master)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 32'(stream.output_valid), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_done"},  32'(done), 32'd0);
   endtask

   // Entered in the first cycle after start was accepted; returns in the done cycle.
   task automatic drain(input int n, input logic [7:0] d, input logic [15:0] pat,
                        input int plen, input int exp_done, input bit poke);
      int xfers;
      int done_at;
      xfers   = 0;
      done_at = -1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         stream.output_ready = (plen == 0) ? 1'b1 : pat[cyc % plen];
         if (poke && cyc == 1) begin
            start        = 1'b1;
            constant_in  = 8'hFF;
            burst_length = 8'd2;
         end
         if (poke && cyc == 2) start = 1'b0;
         if (xfers < n) begin
            chk("valid_held",    32'(stream.output_valid), 32'd1);
            chk("busy_run",      32'(busy), 32'd1);
            chk("state_run",     32'(fsm_state), 32'(ST_RUN));
            chk("data_stable",   32'(stream.output_data), 32'(d));
            chk("no_early_done", 32'(done), 32'd0);
         end
         if (stream.output_valid && stream.output_ready) xfers++;
         if (done) begin
            done_at = cyc;
            break;
         end
         step();
      end
      chk("xfer_count",   32'(xfers), 32'(n));
      chk("done_latency", 32'(done_at), 32'(exp_done));
      chk("valid_at_done", 32'(stream.output_valid), 32'd0);
      chk("busy_at_done",  32'(busy), 32'd0);
      stream.output_ready = 1'b0;
   endtask

   initial begin
      clear               = 1'b1;
      start               = 1'b0;
      constant_in         = 8'h00;
      burst_length        = 8'd0;
      stream.output_ready = 1'b0;
      #1;
      chk_idle("reset");
      chk("reset_data",  32'(stream.output_data), 32'd0);
      chk("reset_state", 32'(fsm_state), 32'(ST_IDLE));
      step();
      step();
      clear = 1'b0;

      // Idle with no start.
      for (int i = 0; i < 3; i++) begin
         step();
         chk_idle("idle");
         chk("idle_data", 32'(stream.output_data), 32'd0);
      end

      // Burst of 3 with ready held high.
      constant_in  = 8'hA5;
      burst_length = 8'd3;
      start        = 1'b1;
      step();
      start = 1'b0;
      drain(3, 8'hA5, 16'h0000, 0, 3, 1'b0);
      step();
      chk_idle("after_a5");

      // Burst of 4 with ready pattern 1,0,0,1,1,0,1.
      constant_in  = 8'h4B;
      burst_length = 8'd4;
      start        = 1'b1;
      step();
      start = 1'b0;
      drain(4, 8'h4B, 16'h0059, 7, 7, 1'b0);
      step();
      chk_idle("after_pattern");

      // Zero-length burst.
      burst_length = 8'd0;
      start        = 1'b1;
      step();
      start = 1'b0;
      chk("zero_done",  32'(done), 32'd1);
      chk("zero_valid", 32'(stream.output_valid), 32'd0);
      chk("zero_busy",  32'(busy), 32'd0);

      // Start in the done cycle is accepted.
      constant_in  = 8'h5A;
      burst_length = 8'd1;
      start        = 1'b1;
      step();
      start = 1'b0;
      drain(1, 8'h5A, 16'h0000, 0, 1, 1'b0);
      step();
      chk_idle("after_5a");

      // Restart attempt during a burst of 5 is ignored.
      constant_in  = 8'h3C;
      burst_length = 8'd5;
      start        = 1'b1;
      step();
      start = 1'b0;
      drain(5, 8'h3C, 16'h0000, 0, 5, 1'b1);
      step();
      chk_idle("after_ignore");

      // Clear after the 2nd of 8 transfers.
      constant_in  = 8'h77;
      burst_length = 8'd8;
      start        = 1'b1;
      step();
      start               = 1'b0;
      stream.output_ready = 1'b1;
      step();
      step();
      chk("pre_clear_valid", 32'(stream.output_valid), 32'd1);
      clear = 1'b1;
      #1;
      chk_idle("clear_now");
      chk("clear_data",  32'(stream.output_data), 32'd0);
      chk("clear_state", 32'(fsm_state), 32'(ST_IDLE));
      step();
      clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_idle("post_clear");
      end
      constant_in  = 8'h11;
      burst_length = 8'd2;
      start        = 1'b1;
      step();
      start = 1'b0;
      drain(2, 8'h11, 16'h0000, 0, 2, 1'b0);
      step();
      chk_idle("after_11");

      // Maximum length burst.
      constant_in  = 8'hC3;
      burst_length = 8'd255;
      start        = 1'b1;
      step();
      start = 1'b0;
      drain(255, 8'hC3, 16'h0000, 0, 255, 1'b0);
      step();
      chk_idle("after_max");
      step();
      chk_idle("after_max2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
